out_bus_arbiter: RTL and testbench
==================================

OUT_BUS_ARBITER -- requirements
Module: out_bus_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, minimum dwell in cycles a granted requester keeps the bus against competitors; legal range 1..15.
REQ-002 clk  input  1  single clock, rising edge; in the top-level wrapper this is io_in[0].
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  3  per-requester bus request, bit i = requester i, level-sensitive.
REQ-005 data0 / data1 / data2  input  8 each  value requester i drives onto the bus while granted.
REQ-006 grant  output  3  one-hot (or zero) grant, registered.
REQ-007 bus_out  output  8  shared output bus, intended for io_out[7:0].
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 lock  input  3  present only when ARB_LOCK_EN is defined (see Configuration).

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, HOLD and GAP.
REQ-011 bus_out SHALL be a combinational mux: the data of the granted requester when grant is non-zero, 8'h00 otherwise.
REQ-012 Round-robin pointer last: on arbitration the winner SHALL be the first requesting index after last, searching modulo 3.
REQ-013 IDLE or GAP with any req bit high at a rising edge SHALL load the winner's one-hot into grant, update last, clear dwell counter cnt, and enter HOLD; grant is visible one cycle after req is sampled.
REQ-014 IDLE or GAP with req == 0 SHALL go to IDLE with grant = 0.
REQ-015 In HOLD, cnt SHALL increment each cycle and saturate at HOLD_CYCLES-1.
REQ-016 In HOLD, holder's req low SHALL end the grant at the next edge regardless of cnt: grant to 0, state GAP.
REQ-017 In HOLD, with holder's req high, cnt == HOLD_CYCLES-1 and any other req high, the arbiter SHALL go to GAP with grant = 0.
REQ-018 In HOLD, with holder's req high and no other requester, grant SHALL persist indefinitely.
REQ-019 GAP SHALL last exactly one cycle with grant = 0 and bus_out = 8'h00; there are no back-to-back grants.
REQ-020 Simultaneous requests in IDLE SHALL be resolved solely by REQ-012.
REQ-021 With HOLD_CYCLES = 1, a contested holder SHALL yield after a single HOLD cycle.
REQ-022 cnt width SHALL be 4 bits; no arithmetic overflow is permitted by REQ-015.

Reset
REQ-023 rst_n low SHALL immediately and asynchronously force state IDLE, grant 3'b000, bus_out 8'h00, busy 0, cnt 0 and last 2, so requester 0 wins first.
REQ-024 Reset asserted mid-HOLD SHALL drop the grant without a GAP cycle; after release, arbitration restarts per REQ-013 on the first rising edge.

Configuration
REQ-025 Macro ARB_LOCK_EN: when defined, the lock[2:0] port exists; while holder's req and lock are both high, REQ-017 SHALL NOT fire and competitors wait, while REQ-016 still applies.
REQ-026 When ARB_LOCK_EN is not defined, the lock port SHALL be absent and the behaviour SHALL be exactly REQ-010..REQ-022.

Verification
REQ-027 Reset then req=3'b111, data0=8'hA0, data1=8'hB1, data2=8'hC2, HOLD_CYCLES=4 -> grant sequence 001(4 cycles), 000, 010(4), 000, 100(4), 000, repeating; bus_out tracks A0/B1/C2 and is 00 in gaps.
REQ-028 Only req[1] high for 20 cycles -> grant 010 for all 20 cycles after the 1-cycle latency; busy high; then req=0 -> one GAP cycle, then IDLE with busy 0.
REQ-029 Holder 0 drops req after 2 HOLD cycles while req[2] is high -> GAP next cycle, then grant 100.
REQ-030 Assert rst_n low asynchronously mid-HOLD (grant 010) -> grant and bus_out 0 within the same cycle without a clock edge; after release with req=111 -> grant 001 first.
REQ-031 ARB_LOCK_EN defined, holder 0 with lock[0]=1 and req=111 for 10 cycles -> grant stays 001; lock[0] low -> yields after the cnt condition to GAP, then 010.

Source files
------------

// File: rtl/out_bus_arbiter_if.sv
// Handshake bundle for the three-requester output bus arbiter.
// The lock field exists only when ARB_LOCK_EN is defined.
interface out_bus_arbiter_if;
  logic [2:0] req;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [2:0] grant;
  logic [7:0] bus_out;
  logic       busy;
`ifdef ARB_LOCK_EN
  logic [2:0] lock;
`endif

  modport master (
`ifdef ARB_LOCK_EN
    output lock,
`endif
    output req, data0, data1, data2,
    input  grant, bus_out, busy
  );

  modport slave (
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    input  req, data0, data1, data2,
    output grant, bus_out, busy
  );
endinterface

// File: rtl/out_bus_arbiter.sv
// Round-robin arbiter for one shared 8-bit output bus with minimum dwell and a one-cycle gap.
// Optional feature macro ARB_LOCK_EN adds a per-requester lock that defers contested yielding.
module out_bus_arbiter #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  out_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(HOLD_CYCLES - 1);

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic [1:0] last_reg;
  logic [2:0] grant_reg;

  logic [1:0] winner;
  logic       holder_req;
  logic       contested;
  logic       locked;

  // First requesting index after last, searching modulo 3.
  function automatic logic [1:0] next_winner(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] w;
    w = 2'd0;
    case (l)
      2'd0:    w = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
      2'd1:    w = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
      default: w = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
    endcase
    return w;
  endfunction

  assign winner     = next_winner(bus.req, last_reg);
  assign holder_req = bus.req[last_reg];
  assign contested  = |(bus.req & ~grant_reg);

`ifdef ARB_LOCK_EN
  assign locked = bus.lock[last_reg];
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      last_reg  <= 2'd2;
      grant_reg <= 3'b000;
    end else begin
      case (state_reg)
        IDLE, GAP: begin
          if (|bus.req) begin
            grant_reg <= 3'b001 << winner;
            last_reg  <= winner;
            cnt_reg   <= 4'd0;
            state_reg <= HOLD;
          end else begin
            grant_reg <= 3'b000;
            state_reg <= IDLE;
          end
        end
        HOLD: begin
          if (!holder_req) begin
            grant_reg <= 3'b000;
            state_reg <= GAP;
          end else if (contested && (cnt_reg == CNT_MAX) && !locked) begin
            grant_reg <= 3'b000;
            state_reg <= GAP;
          end else if (cnt_reg != CNT_MAX) begin
            // Saturating dwell counter: an uncontested holder may keep the bus forever.
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        default: begin
          grant_reg <= 3'b000;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Grant is one-hot or zero, so an AND-OR mux yields 8'h00 when nobody holds the bus.
  logic [7:0] data_arr   [3];
  logic [7:0] masked_arr [3];

  assign data_arr[0] = bus.data0;
  assign data_arr[1] = bus.data1;
  assign data_arr[2] = bus.data2;

  for (genvar gi = 0; gi < 3; gi++) begin : g_mux
    assign masked_arr[gi] = grant_reg[gi] ? data_arr[gi] : 8'h00;
  end

  assign bus.bus_out = masked_arr[0] | masked_arr[1] | masked_arr[2];
  assign bus.grant   = grant_reg;
  assign bus.busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_out_bus_arbiter.sv
// Bench for out_bus_arbiter: two instances (HOLD_CYCLES 4 and 1) against a tenure-count model.
// Define ARB_LOCK_EN to also exercise the lock input.
module tb_out_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] lock = 3'b000;
  logic [7:0] d0 = 8'hA0;
  logic [7:0] d1 = 8'hB1;
  logic [7:0] d2 = 8'hC2;

`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  out_bus_arbiter_if if4();
  out_bus_arbiter_if if1();

  assign if4.req = req;  assign if4.data0 = d0;  assign if4.data1 = d1;  assign if4.data2 = d2;
  assign if1.req = req;  assign if1.data0 = d0;  assign if1.data1 = d1;  assign if1.data2 = d2;
`ifdef ARB_LOCK_EN
  assign if4.lock = lock;
  assign if1.lock = lock;
`endif

  out_bus_arbiter #(.HOLD_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  out_bus_arbiter #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Model: who holds the bus, for how many visible cycles, whether a gap is pending.
  int holder [2];
  int held   [2];
  int last   [2];
  bit gap    [2];

  function automatic int hold_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic logic [7:0] data_of(input int idx);
    return (idx == 0) ? d0 : (idx == 1) ? d1 : d2;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      holder[k] = -1;
      held[k]   = 0;
      last[k]   = 2;
      gap[k]    = 1'b0;
    end
  endtask

  task automatic model_step(input logic [2:0] r, input logic [2:0] lk);
    for (int k = 0; k < 2; k++) begin
      if (holder[k] >= 0) begin
        int  h;
        bit  others;
        h = holder[k];
        others = 1'b0;
        for (int j = 0; j < 3; j++) if (j != h && r[j]) others = 1'b1;
        if (!r[h]) begin
          holder[k] = -1;
          gap[k]    = 1'b1;
        end else if (others && held[k] >= hold_of(k) && !(LOCK_EN && lk[h])) begin
          holder[k] = -1;
          gap[k]    = 1'b1;
        end else begin
          held[k]++;
        end
      end else begin
        gap[k] = 1'b0;
        for (int d = 1; d <= 3; d++) begin
          int idx;
          idx = (last[k] + d) % 3;
          if (holder[k] < 0 && r[idx]) begin
            holder[k] = idx;
            last[k]   = idx;
            held[k]   = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [2:0] exp_grant(input int k);
    return (holder[k] >= 0) ? 3'(1 << holder[k]) : 3'b000;
  endfunction

  function automatic logic [7:0] exp_bus(input int k);
    return (holder[k] >= 0) ? data_of(holder[k]) : 8'h00;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step(req, lock);
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("m4_grant", {5'd0, if4.grant}, {5'd0, exp_grant(0)});
      chk("m4_bus",   if4.bus_out,        exp_bus(0));
      chk("m4_busy",  {7'd0, if4.busy},   {7'd0, (holder[0] >= 0) || gap[0]});
      chk("m1_grant", {5'd0, if1.grant}, {5'd0, exp_grant(1)});
      chk("m1_bus",   if1.bus_out,        exp_bus(1));
      chk("m1_busy",  {7'd0, if1.busy},   {7'd0, (holder[1] >= 0) || gap[1]});
    end
  end

  function automatic logic [7:0] lit_bus(input logic [2:0] g);
    case (g)
      3'b001:  return 8'hA0;
      3'b010:  return 8'hB1;
      3'b100:  return 8'hC2;
      default: return 8'h00;
    endcase
  endfunction

  task automatic at_drive();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    at_drive();
    rst_n = 1'b0;
    req   = 3'b000;
    lock  = 3'b000;
    d0 = 8'hA0; d1 = 8'hB1; d2 = 8'hC2;
    at_drive();
    at_drive();
    rst_n = 1'b1;
  endtask

  logic [2:0] e27 [16];
  logic [2:0] e21 [7];

  initial begin
    e27 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b010,
            3'b010, 3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};
    e21 = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};

    // Full contention: round-robin rotation with dwell and gap.
    $display("txn: rotation req=111");
    do_reset();
    req = 3'b111;
    @(negedge clk);
    chk("r27_reset_grant", {5'd0, if4.grant}, 8'h00);
    chk("r27_reset_busy",  {7'd0, if4.busy},  8'h00);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("r27_grant", {5'd0, if4.grant}, {5'd0, e27[i]});
      chk("r27_bus",   if4.bus_out,       lit_bus(e27[i]));
      if (i < 7) chk("r21_grant", {5'd0, if1.grant}, {5'd0, e21[i]});
    end

    // Single requester keeps the bus indefinitely, then releases through one gap.
    $display("txn: single requester 1");
    do_reset();
    req = 3'b010;
    @(negedge clk);
    chk("r28_idle_busy", {7'd0, if4.busy}, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("r28_grant4", {5'd0, if4.grant}, 8'h02);
      chk("r28_grant1", {5'd0, if1.grant}, 8'h02);
      chk("r28_bus",    if4.bus_out,       8'hB1);
    end
    at_drive();
    req = 3'b000;
    @(negedge clk);
    chk("r28_last_grant", {5'd0, if4.grant}, 8'h02);
    @(negedge clk);
    chk("r28_gap_grant", {5'd0, if4.grant}, 8'h00);
    chk("r28_gap_busy",  {7'd0, if4.busy},  8'h01);
    chk("r28_gap_bus",   if4.bus_out,       8'h00);
    @(negedge clk);
    chk("r28_idle_busy2", {7'd0, if4.busy}, 8'h00);

    // Holder drops its request early while requester 2 waits.
    $display("txn: early release by holder 0");
    do_reset();
    req = 3'b101;
    @(negedge clk);
    @(negedge clk);
    chk("r29_n1_g4", {5'd0, if4.grant}, 8'h01);
    chk("r29_n1_g1", {5'd0, if1.grant}, 8'h01);
    at_drive();
    req = 3'b100;
    @(negedge clk);
    chk("r29_n2_g4", {5'd0, if4.grant}, 8'h01);
    chk("r29_n2_g1", {5'd0, if1.grant}, 8'h00);
    @(negedge clk);
    chk("r29_n3_g4", {5'd0, if4.grant}, 8'h00);
    chk("r29_n3_g1", {5'd0, if1.grant}, 8'h04);
    @(negedge clk);
    chk("r29_n4_g4", {5'd0, if4.grant}, 8'h04);
    chk("r29_n4_bus", if4.bus_out,      8'hC2);

    // Asynchronous reset mid-hold clears outputs without a clock edge.
    $display("txn: async reset mid-hold");
    do_reset();
    req = 3'b010;
    @(negedge clk);
    @(negedge clk);
    chk("r30_pre_grant", {5'd0, if4.grant}, 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r30_async_grant4", {5'd0, if4.grant}, 8'h00);
    chk("r30_async_bus4",   if4.bus_out,       8'h00);
    chk("r30_async_busy4",  {7'd0, if4.busy},  8'h00);
    chk("r30_async_grant1", {5'd0, if1.grant}, 8'h00);
    at_drive();
    rst_n = 1'b1;
    req   = 3'b111;
    @(negedge clk);
    chk("r30_rel_grant", {5'd0, if4.grant}, 8'h00);
    @(negedge clk);
    chk("r30_first4", {5'd0, if4.grant}, 8'h01);
    chk("r30_first1", {5'd0, if1.grant}, 8'h01);

`ifdef ARB_LOCK_EN
    // Locked holder keeps the bus under contention until the lock drops.
    $display("txn: lock holder 0");
    do_reset();
    lock = 3'b001;
    req  = 3'b111;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("r31_locked4", {5'd0, if4.grant}, 8'h01);
      chk("r31_locked1", {5'd0, if1.grant}, 8'h01);
    end
    at_drive();
    lock = 3'b000;
    @(negedge clk);
    chk("r31_unlock_edge", {5'd0, if4.grant}, 8'h01);
    @(negedge clk);
    chk("r31_gap", {5'd0, if4.grant}, 8'h00);
    @(negedge clk);
    chk("r31_next", {5'd0, if4.grant}, 8'h02);
`endif

    // Randomized traffic with occasional mid-cycle resets.
    $display("txn: random traffic 800 cycles");
    do_reset();
    for (int i = 0; i < 800; i++) begin
      at_drive();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 59) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 3) == 0) req = 3'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        d2 = 8'($urandom);
      end
      if (LOCK_EN && $urandom_range(0, 7) == 0) lock = 3'($urandom);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
